module_mem_cache_assoc: RTL and testbench

N-way set-associative, write-through, write-allocate cache between CPU and main memory; next generation of the team's direct-mapped cache. Adds:
- parametrised associativity with round-robin replacement
- byte-strobed CPU writes
- a real write-through handshake to memory, including after write-miss fills
- whole-cache invalidate
- saturating hit/miss counters

---
 rtl/module_mem_cache_assoc.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_module_mem_cache_assoc.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_mem_cache_assoc.sv
// N-way set-associative, write-through, write-allocate cache with round-robin
// replacement, byte-strobed writes, whole-cache invalidate and hit/miss counters.
module module_mem_cache_assoc #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 32,
    parameter int CACHE_BYTES = 1024,
    parameter int NUM_WAYS    = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    cpu_read_en,
    input  logic                    cpu_write_en,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    input  logic [DATA_WIDTH-1:0]   cpu_write_data,
    output logic [DATA_WIDTH-1:0]   cpu_read_data,
    output logic                    cpu_ready,
    output logic                    cpu_hit,
    input  logic                    inv_all,
    output logic                    mem_rd_req,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic                    mem_rd_ack,
    input  logic [BLOCK_SIZE*8-1:0] mem_rd_data,
    output logic                    mem_wr_req,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_strb,
    input  logic                    mem_wr_ack,
    output logic [CNT_WIDTH-1:0]    hit_count,
    output logic [CNT_WIDTH-1:0]    miss_count
);
    localparam int BPW         = DATA_WIDTH / 8;
    localparam int WORD_OFF    = $clog2(BPW);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int LINES       = CACHE_BYTES / BLOCK_SIZE;
    localparam int SETS        = LINES / NUM_WAYS;
    localparam int INDEX_BITS  = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int IDX_W       = (SETS > 1) ? INDEX_BITS : 1;
    localparam int TAG_W       = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int WORDS       = BLOCK_SIZE / BPW;
    localparam int WSEL_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LIDX_W      = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int LINE_BITS   = BLOCK_SIZE * 8;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return (SETS > 1) ? a[OFFSET_BITS +: IDX_W] : '0;
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1 -: TAG_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_wsel(input logic [ADDR_WIDTH-1:0] a);
        return (WORDS > 1) ? a[WORD_OFF +: WSEL_W] : '0;
    endfunction

    function automatic logic [LIDX_W-1:0] line_of(input logic [IDX_W-1:0] idx,
                                                  input logic [WAY_W-1:0] way);
        return LIDX_W'(idx) * LIDX_W'(NUM_WAYS) + LIDX_W'(way);
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_line(input logic [LINE_BITS-1:0] line,
                                                        input logic [WSEL_W-1:0] wsel,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [BPW-1:0] st);
        logic [LINE_BITS-1:0] r;
        r = line;
        for (int b = 0; b < BPW; b++) begin
            if (st[b]) r[int'(wsel)*DATA_WIDTH + b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    logic [LINE_BITS-1:0] data_mem [LINES];
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINES-1:0]     valid_reg;
    logic [WAY_W-1:0]     rr_reg   [SETS];

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   req_addr_reg, req_addr_next;
    logic [DATA_WIDTH-1:0]   req_wdata_reg, req_wdata_next;
    logic [BPW-1:0]          req_wstrb_reg, req_wstrb_next;
    logic                    req_write_reg, req_write_next;
    logic                    req_hit_reg, req_hit_next;
    logic [WAY_W-1:0]        req_way_reg, req_way_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    ready_reg, ready_next;
    logic                    hit_out_reg, hit_out_next;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr_reg, mem_rd_addr_next;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr_reg, mem_wr_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wr_data_reg, mem_wr_data_next;
    logic [BPW-1:0]          mem_wr_strb_reg, mem_wr_strb_next;
    logic [CNT_WIDTH-1:0]    hit_cnt_reg, hit_cnt_next;
    logic [CNT_WIDTH-1:0]    miss_cnt_reg, miss_cnt_next;

    logic [IDX_W-1:0]     look_idx, req_idx;
    logic [TAG_W-1:0]     look_tag, req_tag;
    logic [WSEL_W-1:0]    look_wsel, req_wsel;
    logic [LIDX_W-1:0]    look_line [NUM_WAYS];
    logic [NUM_WAYS-1:0]  hit_vec, req_valid_vec;
    logic [WAY_W-1:0]     hit_way, victim;
    logic                 look_hit, req_any, accept;
    logic [LIDX_W-1:0]    look_line_sel, req_line;
    logic [LINE_BITS-1:0] look_data, fill_line;
    logic [DATA_WIDTH-1:0] look_word, fill_word;
    logic                 install_en, wr_hit_en, inv_en, hit_inc, miss_inc;

    assign look_idx  = addr_idx(cpu_addr);
    assign look_tag  = addr_tag(cpu_addr);
    assign look_wsel = addr_wsel(cpu_addr);
    assign req_idx   = addr_idx(req_addr_reg);
    assign req_tag   = addr_tag(req_addr_reg);
    assign req_wsel  = addr_wsel(req_addr_reg);
    assign req_line  = line_of(req_idx, req_way_reg);

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign look_line[gi]     = line_of(look_idx, WAY_W'(gi));
            assign hit_vec[gi]       = valid_reg[look_line[gi]] && (tag_mem[look_line[gi]] == look_tag);
            assign req_valid_vec[gi] = valid_reg[line_of(req_idx, WAY_W'(gi))];
        end
    endgenerate

    // Descending scan leaves the lowest-numbered invalid way as the victim.
    always_comb begin
        hit_way = '0;
        victim  = rr_reg[look_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_reg[look_line[w]]) victim = WAY_W'(w);
        end
    end

    assign look_hit      = |hit_vec;
    assign look_line_sel = line_of(look_idx, hit_way);
    assign look_data     = data_mem[look_line_sel];
    assign look_word     = look_data[int'(look_wsel)*DATA_WIDTH +: DATA_WIDTH];
    assign fill_word     = mem_rd_data[int'(req_wsel)*DATA_WIDTH +: DATA_WIDTH];
    assign fill_line     = req_write_reg ? merge_line(mem_rd_data, req_wsel, req_wdata_reg, req_wstrb_reg)
                                         : mem_rd_data;
    assign req_any       = cpu_read_en | cpu_write_en;
    assign accept        = (state_reg == S_IDLE) && req_any && !ready_reg;

    always_comb begin
        state_next       = state_reg;
        req_addr_next    = req_addr_reg;
        req_wdata_next   = req_wdata_reg;
        req_wstrb_next   = req_wstrb_reg;
        req_write_next   = req_write_reg;
        req_hit_next     = req_hit_reg;
        req_way_next     = req_way_reg;
        rdata_next       = rdata_reg;
        mem_rd_addr_next = mem_rd_addr_reg;
        mem_wr_addr_next = mem_wr_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        mem_wr_strb_next = mem_wr_strb_reg;
        ready_next       = 1'b0;
        hit_out_next     = 1'b0;
        install_en       = 1'b0;
        wr_hit_en        = 1'b0;
        inv_en           = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    req_addr_next  = cpu_addr;
                    req_wdata_next = cpu_write_data;
                    req_wstrb_next = cpu_wstrb;
                    req_write_next = cpu_write_en;
                    req_hit_next   = look_hit;
                    req_way_next   = look_hit ? hit_way : victim;
                    if (look_hit && cpu_write_en) begin
                        wr_hit_en        = 1'b1;
                        mem_wr_addr_next = cpu_addr & WORD_MASK;
                        mem_wr_data_next = cpu_write_data;
                        mem_wr_strb_next = cpu_wstrb;
                        state_next       = S_WRITE;
                    end else if (look_hit) begin
                        rdata_next   = look_word;
                        ready_next   = 1'b1;
                        hit_out_next = 1'b1;
                        hit_inc      = 1'b1;
                    end else begin
                        mem_rd_addr_next = cpu_addr & BLOCK_MASK;
                        state_next       = S_FILL;
                    end
                end else if (inv_all && !req_any) begin
                    inv_en = 1'b1;
                end
            end
            S_FILL: begin
                if (mem_rd_ack) begin
                    install_en = 1'b1;
                    if (req_write_reg) begin
                        mem_wr_addr_next = req_addr_reg & WORD_MASK;
                        mem_wr_data_next = req_wdata_reg;
                        mem_wr_strb_next = req_wstrb_reg;
                        state_next       = S_WRITE;
                    end else begin
                        rdata_next = fill_word;
                        ready_next = 1'b1;
                        miss_inc   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_wr_ack) begin
                    ready_next   = 1'b1;
                    hit_out_next = req_hit_reg;
                    hit_inc      = req_hit_reg;
                    miss_inc     = !req_hit_reg;
                    state_next   = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        hit_cnt_next  = (hit_inc && hit_cnt_reg != {CNT_WIDTH{1'b1}}) ? hit_cnt_reg + 1'b1 : hit_cnt_reg;
        miss_cnt_next = (miss_inc && miss_cnt_reg != {CNT_WIDTH{1'b1}}) ? miss_cnt_reg + 1'b1 : miss_cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            req_addr_reg    <= '0;
            req_wdata_reg   <= '0;
            req_wstrb_reg   <= '0;
            req_write_reg   <= 1'b0;
            req_hit_reg     <= 1'b0;
            req_way_reg     <= '0;
            rdata_reg       <= '0;
            ready_reg       <= 1'b0;
            hit_out_reg     <= 1'b0;
            mem_rd_addr_reg <= '0;
            mem_wr_addr_reg <= '0;
            mem_wr_data_reg <= '0;
            mem_wr_strb_reg <= '0;
            hit_cnt_reg     <= '0;
            miss_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            req_addr_reg    <= req_addr_next;
            req_wdata_reg   <= req_wdata_next;
            req_wstrb_reg   <= req_wstrb_next;
            req_write_reg   <= req_write_next;
            req_hit_reg     <= req_hit_next;
            req_way_reg     <= req_way_next;
            rdata_reg       <= rdata_next;
            ready_reg       <= ready_next;
            hit_out_reg     <= hit_out_next;
            mem_rd_addr_reg <= mem_rd_addr_next;
            mem_wr_addr_reg <= mem_wr_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
            mem_wr_strb_reg <= mem_wr_strb_next;
            hit_cnt_reg     <= hit_cnt_next;
            miss_cnt_reg    <= miss_cnt_next;
        end
    end

    // Round-robin pointer only moves when a fill displaces a valid line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || inv_en) begin
            valid_reg <= '0;
            for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
        end else if (install_en) begin
            valid_reg[req_line] <= 1'b1;
            if (&req_valid_vec) begin
                rr_reg[req_idx] <= (rr_reg[req_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_reg[req_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install_en) begin
            data_mem[req_line] <= fill_line;
            tag_mem[req_line]  <= req_tag;
        end else if (wr_hit_en) begin
            data_mem[look_line_sel] <= merge_line(look_data, look_wsel, cpu_write_data, cpu_wstrb);
        end
    end

    assign cpu_read_data = rdata_reg;
    assign cpu_ready     = ready_reg;
    assign cpu_hit       = hit_out_reg;
    assign mem_rd_req    = (state_reg == S_FILL);
    assign mem_rd_addr   = mem_rd_addr_reg;
    assign mem_wr_req    = (state_reg == S_WRITE);
    assign mem_wr_addr   = mem_wr_addr_reg;
    assign mem_wr_data   = mem_wr_data_reg;
    assign mem_wr_strb   = mem_wr_strb_reg;
    assign hit_count     = hit_cnt_reg;
    assign miss_count    = miss_cnt_reg;
endmodule

// File: tb/tb_module_mem_cache_assoc.sv
// Scoreboard bench for module_mem_cache_assoc: directed scenarios then random traffic,
// checked against a set/way/round-robin model and a byte-level memory image.
module tb_module_mem_cache_assoc;
    localparam int SETS = 16;
    localparam int NW   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  cpu_addr = '0;
    logic         cpu_read_en = 1'b0, cpu_write_en = 1'b0, inv_all = 1'b0;
    logic [3:0]   cpu_wstrb = '0;
    logic [31:0]  cpu_write_data = '0;
    logic [31:0]  cpu_read_data;
    logic         cpu_ready, cpu_hit, mem_rd_req, mem_wr_req;
    logic [15:0]  mem_rd_addr, mem_wr_addr;
    logic         mem_rd_ack = 1'b0, mem_wr_ack = 1'b0;
    logic [255:0] mem_rd_data = '0;
    logic [31:0]  mem_wr_data;
    logic [3:0]   mem_wr_strb;
    logic [15:0]  hit_count, miss_count;
    // second instance with 2-bit counters to exercise saturation
    logic [31:0]  s_read_data, s_wr_data;
    logic         s_ready, s_hit, s_rd_req, s_wr_req;
    logic [15:0]  s_rd_addr, s_wr_addr;
    logic [3:0]   s_wr_strb;
    logic [1:0]   s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    module_mem_cache_assoc dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read_en(cpu_read_en),
        .cpu_write_en(cpu_write_en), .cpu_wstrb(cpu_wstrb), .cpu_write_data(cpu_write_data),
        .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .inv_all(inv_all),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    module_mem_cache_assoc #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read_en(cpu_read_en),
        .cpu_write_en(cpu_write_en), .cpu_wstrb(cpu_wstrb), .cpu_write_data(cpu_write_data),
        .cpu_read_data(s_read_data), .cpu_ready(s_ready), .cpu_hit(s_hit), .inv_all(inv_all),
        .mem_rd_req(s_rd_req), .mem_rd_addr(s_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_wr_req(s_wr_req), .mem_wr_addr(s_wr_addr),
        .mem_wr_data(s_wr_data), .mem_wr_strb(s_wr_strb), .mem_wr_ack(mem_wr_ack),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] sim_mem [65536];
    logic [7:0] ref_mem [65536];

    bit  mv  [SETS][NW];
    int  mt  [SETS][NW];
    int  mrr [SETS];
    int  m_hits = 0, m_misses = 0, txn_no = 0;
    logic [31:0] last_rd = '0;

    typedef struct { bit is_write; logic [15:0] addr; logic [31:0] data; bit hit; } cpu_exp_t;
    typedef struct { logic [15:0] addr; logic [31:0] data; logic [3:0] strb; } wr_exp_t;
    cpu_exp_t    cpu_q[$];
    wr_exp_t     wr_q[$];
    logic [15:0] rd_q[$];

    int rd_delay = 0, wr_delay = 0;
    bit hold_rd = 0, late_ack = 0;

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        logic [15:0] wa;
        wa = a & 16'hFFFC;
        return {ref_mem[wa + 16'd3], ref_mem[wa + 16'd2], ref_mem[wa + 16'd1], ref_mem[wa]};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < NW; w++) mv[s][w] = 0;
        end
    endtask

    // Reference behaviour: lowest invalid way, else round-robin; write-through keeps
    // cache contents equal to memory, so reads return the memory image.
    task automatic model_access(input logic [15:0] addr, input bit write, input logic [31:0] wdata,
                                input logic [3:0] strb, output bit hit);
        int set, tag, victim;
        cpu_exp_t e;
        wr_exp_t  we;
        logic [15:0] wa;
        set = (int'(addr) >> 5) % SETS;
        tag = int'(addr) >> 9;
        hit = 0;
        for (int w = 0; w < NW; w++) if (mv[set][w] && mt[set][w] == tag) hit = 1;
        if (!hit) begin
            victim = -1;
            for (int w = 0; w < NW; w++) if (!mv[set][w] && victim < 0) victim = w;
            if (victim < 0) begin
                victim   = mrr[set];
                mrr[set] = (mrr[set] + 1) % NW;
            end
            mv[set][victim] = 1;
            mt[set][victim] = tag;
            rd_q.push_back(addr & 16'hFFE0);
        end
        if (write) begin
            wa = addr & 16'hFFFC;
            for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[wa + 16'(b)] = wdata[b*8 +: 8];
            we.addr = wa; we.data = wdata; we.strb = strb;
            wr_q.push_back(we);
        end
        if (hit) m_hits++; else m_misses++;
        if (!write) last_rd = ref_word(addr);
        e.is_write = write; e.addr = addr; e.data = last_rd; e.hit = hit;
        cpu_q.push_back(e);
    endtask

    task automatic do_access(input logic [15:0] addr, input bit write, input bit both,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             output bit got_hit, output logic [31:0] got_data);
        bit exp_hit, done;
        int lat;
        model_access(addr, write, wdata, strb, exp_hit);
        cpu_addr       = addr;
        cpu_write_en   = write;
        cpu_read_en    = !write || both;
        cpu_write_data = wdata;
        cpu_wstrb      = strb;
        done = 0;
        lat  = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ready) done = 1;
        end
        check("ready_within_bound", 256'(done), 256'(1));
        got_hit  = cpu_hit;
        got_data = cpu_read_data;
        if (done && !write && exp_hit) check("read_hit_latency", 256'(lat), 256'(1));
        cpu_read_en  = 0;
        cpu_write_en = 0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_inv();
        inv_all = 1;
        @(posedge clk); #1;
        inv_all = 0;
        model_clear();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"}, 256'(hit_count), 256'(m_hits));
        check({tag, "_miss_count"}, 256'(miss_count), 256'(m_misses));
        check({tag, "_sat_hit"}, 256'(s_hit_count), 256'((m_hits > 3) ? 3 : m_hits));
        check({tag, "_sat_miss"}, 256'(s_miss_count), 256'((m_misses > 3) ? 3 : m_misses));
    endtask

    // CPU-side monitor
    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (cpu_q.size() == 0) begin
                check("unexpected_ready", 256'(cpu_ready), 256'(0));
            end else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                txn_no++;
                check("cpu_hit", 256'(cpu_hit), 256'(e.hit));
                check(e.is_write ? "rdata_hold" : "rdata", 256'(cpu_read_data), 256'(e.data));
                $display("[TB] txn %0d %s addr=%h hit=%0d rdata=%h", txn_no,
                         e.is_write ? "WR" : "RD", e.addr, cpu_hit, cpu_read_data);
            end
        end
    end

    // Memory read responder
    initial begin
        int rd_wait;
        logic [15:0] exp_a;
        rd_wait = 0;
        forever begin
            @(posedge clk); #1;
            mem_rd_ack = 0;
            if (late_ack) begin
                mem_rd_data = {8{32'h0BADF00D}};
                mem_rd_ack  = 1;
                late_ack    = 0;
            end else if (mem_rd_req && !rst && !hold_rd) begin
                if (rd_wait >= rd_delay) begin
                    rd_wait = 0;
                    if (rd_q.size() == 0) begin
                        check("mem_rd_unexpected", 256'(mem_rd_req), 256'(0));
                    end else begin
                        exp_a = rd_q.pop_front();
                        check("mem_rd_addr", 256'(mem_rd_addr), 256'(exp_a));
                    end
                    for (int b = 0; b < 32; b++) mem_rd_data[b*8 +: 8] = sim_mem[mem_rd_addr + 16'(b)];
                    mem_rd_ack = 1;
                end else begin
                    rd_wait++;
                end
            end else begin
                rd_wait = 0;
            end
        end
    end

    // Memory write responder
    initial begin
        int wr_wait;
        wr_exp_t e;
        wr_wait = 0;
        forever begin
            @(posedge clk); #1;
            mem_wr_ack = 0;
            if (mem_wr_req && !rst) begin
                if (wr_wait >= wr_delay) begin
                    wr_wait = 0;
                    if (wr_q.size() == 0) begin
                        check("mem_wr_unexpected", 256'(mem_wr_req), 256'(0));
                    end else begin
                        e = wr_q.pop_front();
                        check("mem_wr_addr", 256'(mem_wr_addr), 256'(e.addr));
                        check("mem_wr_data", 256'(mem_wr_data), 256'(e.data));
                        check("mem_wr_strb", 256'(mem_wr_strb), 256'(e.strb));
                    end
                    for (int b = 0; b < 4; b++)
                        if (mem_wr_strb[b]) sim_mem[mem_wr_addr + 16'(b)] = mem_wr_data[b*8 +: 8];
                    mem_wr_ack = 1;
                end else begin
                    wr_wait++;
                end
            end else begin
                wr_wait = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gh;
        logic [31:0] gd;
        int k;
        for (int i = 0; i < 65536; i++) begin
            sim_mem[i] = 8'(i * 7 + (i >> 8) * 13);
            ref_mem[i] = sim_mem[i];
        end
        {sim_mem[16'h47], sim_mem[16'h46], sim_mem[16'h45], sim_mem[16'h44]} = 32'hDEADBEEF;
        {ref_mem[16'h47], ref_mem[16'h46], ref_mem[16'h45], ref_mem[16'h44]} = 32'hDEADBEEF;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 256'({cpu_read_data, cpu_ready, cpu_hit, mem_rd_req, mem_rd_addr,
              mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb, hit_count, miss_count}), 256'(0));
        rst = 0;
        @(posedge clk); #1;

        // cold miss, then hit
        rd_delay = 3;
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t1_cold_hit", 256'(gh), 256'(0));
        check("t1_cold_data", 256'(gd), 256'(32'hDEADBEEF));
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t1_reread_hit", 256'(gh), 256'(1));
        check_counters("t1");
        rd_delay = 1; wr_delay = 2;

        // strobed write hit
        do_access(16'h0044, 1, 0, 32'h11223344, 4'b0011, gh, gd);
        check("t2_write_hit", 256'(gh), 256'(1));
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t2_merged_data", 256'(gd), 256'(32'hDEAD3344));

        // write miss into way1 of set 2
        do_access(16'h0248, 1, 0, 32'hCAFEF00D, 4'hF, gh, gd);
        check("t3_write_miss", 256'(gh), 256'(0));
        do_access(16'h0248, 0, 0, 0, 0, gh, gd);
        check("t3_read_back", 256'(gd), 256'(32'hCAFEF00D));
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t3_way0_kept", 256'(gh), 256'(1));

        // replacement in the full set
        do_access(16'h0440, 0, 0, 0, 0, gh, gd);
        check("t4_0440_miss", 256'(gh), 256'(0));
        do_access(16'h0240, 0, 0, 0, 0, gh, gd);
        check("t4_0240_hit", 256'(gh), 256'(1));
        do_access(16'h0040, 0, 0, 0, 0, gh, gd);
        check("t4_0040_miss", 256'(gh), 256'(0));
        do_access(16'h0440, 0, 0, 0, 0, gh, gd);
        check("t4_0440_hit", 256'(gh), 256'(1));
        do_access(16'h0240, 0, 0, 0, 0, gh, gd);
        check("t4_0240_evicted", 256'(gh), 256'(0));

        // invalidate, zero strobe, simultaneous read+write
        pulse_inv();
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t5_inv_miss_a", 256'(gh), 256'(0));
        do_access(16'h0248, 0, 0, 0, 0, gh, gd);
        check("t5_inv_miss_b", 256'(gh), 256'(0));
        do_access(16'h0248, 1, 0, 32'h55555555, 4'h0, gh, gd);
        do_access(16'h0044, 1, 1, 32'hA5A5A5A5, 4'hF, gh, gd);
        check("t5_both_is_write", 256'(gh), 256'(1));
        do_access(16'h0044, 0, 0, 0, 0, gh, gd);
        check("t5_both_data", 256'(gd), 256'(32'hA5A5A5A5));
        do_access(16'h0248, 0, 0, 0, 0, gh, gd);
        check("t5_zero_strobe_data", 256'(gd), 256'(32'hCAFEF00D));
        check_counters("t5");

        // reset during an outstanding fill, with a late ack
        hold_rd = 1;
        cpu_addr = 16'h0100;
        cpu_read_en = 1;
        k = 0;
        while (!mem_rd_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_rd_req_seen", 256'(mem_rd_req), 256'(1));
        rst = 1;
        cpu_read_en = 0;
        #1;
        check("t6_outputs_in_reset", 256'({cpu_read_data, cpu_ready, cpu_hit, mem_rd_req, mem_rd_addr,
              mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb, hit_count, miss_count}), 256'(0));
        model_clear();
        m_hits = 0; m_misses = 0; last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        late_ack = 1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_req_after_late_ack", 256'(mem_rd_req), 256'(0));
        check_counters("t6");
        hold_rd = 0;
        do_access(16'h0100, 0, 0, 0, 0, gh, gd);
        check("t6_read_after_reset_miss", 256'(gh), 256'(0));

        // random traffic over two sets with four tags each
        repeat (300) begin
            logic [15:0] a;
            bit wr;
            if ($urandom_range(0, 19) == 0) begin
                pulse_inv();
            end else begin
                a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(2, 3) << 5) |
                        ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
                wr = ($urandom_range(0, 1) == 1);
                rd_delay = $urandom_range(0, 3);
                wr_delay = $urandom_range(0, 3);
                do_access(a, wr, wr && ($urandom_range(0, 3) == 0), $urandom,
                          4'($urandom_range(0, 15)), gh, gd);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check_counters("final");
        check("cpu_q_drained", 256'(cpu_q.size()), 256'(0));
        check("rd_q_drained", 256'(rd_q.size()), 256'(0));
        check("wr_q_drained", 256'(wr_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
